// File: rtl/titan_dmem_controller.sv
// titan_dmem_controller
// Memory-stage data-bus sequencer. Decodes the EX/MEM memory flags, issues one
// cyc/stb/ack bus transaction per aligned load/store, stalls the pipeline until
// it completes, steers byte lanes, extends load data and reports misaligned
// accesses and bus faults (err or timeout).
//
// Ports
//   i_clk, i_rst_n            clock, async active-low reset
//   i_mem_mem_flags[5:0]      [5] read [4] write [3:2] size [1] unsigned [0] unused
//   i_mem_addr, i_mem_store_data, i_mem_kill
//   o_dmem_addr/wdata/sel/we/cyc/stb, i_dmem_rdata/ack/err   data bus
//   o_mem_load_data, o_mem_stall
//   o_exc_load_misaligned, o_exc_store_misaligned, o_mem_bus_access_fault
//
// state | meaning
// IDLE  | waiting for an aligned access; stalls combinationally when one appears
// BUSY  | bus request asserted, waiting for ack/err or timeout
// DONE  | result/fault presented for one cycle, pipeline advances
module titan_dmem_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [5:0]  i_mem_mem_flags,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_store_data,
  input  logic        i_mem_kill,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_sel,
  output logic        o_dmem_we,
  output logic        o_dmem_cyc,
  output logic        o_dmem_stb,
  input  logic [31:0] i_dmem_rdata,
  input  logic        i_dmem_ack,
  input  logic        i_dmem_err,
  output logic [31:0] o_mem_load_data,
  output logic        o_mem_stall,
  output logic        o_exc_load_misaligned,
  output logic        o_exc_store_misaligned,
  output logic        o_mem_bus_access_fault
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] C_TC = 8'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr, r_wdata, r_load_data;
  logic [3:0]  r_sel;
  logic        r_we, r_fault, r_unsigned;
  logic [1:0]  r_size, r_lo;

  logic        w_rd, w_wr, w_access, w_misaligned, w_go;
  logic        w_busy, w_timeout, w_fault_evt;
  logic [1:0]  w_size;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata, w_shifted, w_load_ext;
  logic        w_unused;

  assign w_unused = i_mem_mem_flags[0];

  assign w_rd     = i_mem_mem_flags[5];
  assign w_wr     = i_mem_mem_flags[4];
  assign w_size   = i_mem_mem_flags[3:2];
  assign w_access = (w_rd ^ w_wr) & ~i_mem_kill;

  // size 11 (reserved) behaves as a word access
  assign w_misaligned = ((w_size == 2'b01) & i_mem_addr[0]) |
                        (w_size[1] & (i_mem_addr[1:0] != 2'b00));

  assign w_go   = (r_state == IDLE) & w_access & ~w_misaligned;
  assign w_busy = (r_state == BUSY);

  // timeout only when no response arrives in the final allowed cycle
  assign w_timeout   = w_busy & ~i_dmem_ack & ~i_dmem_err & (r_cnt == C_TC);
  assign w_fault_evt = w_busy & (i_dmem_err | w_timeout);

  always_comb begin
    w_sel   = 4'b1111;
    w_wdata = i_mem_store_data;
    case (w_size)
      2'b00: begin
        w_sel   = 4'b0001 << i_mem_addr[1:0];
        w_wdata = {4{i_mem_store_data[7:0]}};
      end
      2'b01: begin
        w_sel   = i_mem_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_mem_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shifted = i_dmem_rdata >> {r_lo, 3'b000};

  always_comb begin
    w_load_ext = w_shifted;
    case (r_size)
      2'b00:   w_load_ext = {{24{~r_unsigned & w_shifted[7]}},  w_shifted[7:0]};
      2'b01:   w_load_ext = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_go) w_state_nxt = BUSY;
      BUSY:    if (i_dmem_ack | i_dmem_err | w_timeout) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_size      <= '0;
      r_lo        <= '0;
      r_unsigned  <= 1'b0;
      r_load_data <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_fault <= w_fault_evt;
      if (w_go) begin
        r_cnt      <= '0;
        r_addr     <= {i_mem_addr[31:2], 2'b00};
        r_wdata    <= w_wdata;
        r_sel      <= w_sel;
        r_we       <= w_wr;
        r_size     <= w_size;
        r_lo       <= i_mem_addr[1:0];
        r_unsigned <= i_mem_mem_flags[1];
      end else if (w_busy & ~i_dmem_ack & ~i_dmem_err) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_fault_evt)
        r_load_data <= '0;
      else if (w_busy & i_dmem_ack & ~r_we)
        r_load_data <= w_load_ext;
    end
  end

  assign o_dmem_addr            = r_addr;
  assign o_dmem_wdata           = r_wdata;
  assign o_dmem_sel             = r_sel;
  assign o_dmem_we              = r_we;
  assign o_dmem_cyc             = w_busy;
  assign o_dmem_stb             = w_busy;
  assign o_mem_load_data        = r_load_data;
  assign o_mem_bus_access_fault = r_fault;

  // combinational outputs are held low while reset is asserted
  assign o_mem_stall            = i_rst_n & (w_go | w_busy);
  assign o_exc_load_misaligned  = i_rst_n & w_access & w_rd & w_misaligned;
  assign o_exc_store_misaligned = i_rst_n & w_access & w_wr & w_misaligned;

endmodule
